// File: rtl/clk_period_meter.sv
// Measures the period of an asynchronous square wave in clk_in cycles.
// Define CLK_PERIOD_AVG_EN to report the truncated mean of 4 samples.
module clk_period_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic             s0;
  logic             s1;
  logic             s2;
  logic             rise;
  logic             armed;
  logic             at_limit;
  logic             take;
  logic             stall_set;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= sig_in;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign rise      = s1 & ~s2;
  assign at_limit  = (cnt == LIMIT);
  assign take      = rise & armed;
  // An edge in the same cycle as the limit wins over the stall.
  assign stall_set = ~rise & at_limit & ~stalled;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (!at_limit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      armed   <= 1'b0;
      stalled <= 1'b0;
    end else if (rise) begin
      armed   <= 1'b1;
      stalled <= 1'b0;
    end else if (stall_set) begin
      armed   <= 1'b0;
      stalled <= 1'b1;
    end
  end

`ifdef CLK_PERIOD_AVG_EN
  logic [CNT_W+1:0] acc;
  logic [CNT_W+1:0] sum;
  logic [1:0]       idx;

  assign sum = acc + {2'b00, cnt};

  always_ff @(posedge clk_in) begin
    if (rst) begin
      acc          <= '0;
      idx          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (stall_set) begin
        acc <= '0;
        idx <= '0;
      end else if (take) begin
        if (idx == 2'd3) begin
          period       <= sum[CNT_W+1:2];
          period_valid <= 1'b1;
          acc          <= '0;
          idx          <= '0;
        end else begin
          acc <= sum;
          idx <= idx + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk_in) begin
    if (rst) begin
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= take;
      if (take) begin
        period <= cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: directed scenarios plus
// randomized periods checked against an edge-timestamp reference model.
module tb_clk_period_meter;

  localparam int CW = 16;
  localparam int T  = 50;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          stalled;

  clk_period_meter #(.CNT_W(CW), .TIMEOUT(T)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sig_in      (sig_in),
    .period      (period),
    .period_valid(period_valid),
    .stalled     (stalled)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int value;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   win[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_armed = 1'b0;
  int   m_last = 0;
  int   last_m = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    m_armed = 1'b0;
    win.delete();
  endfunction

  // m is the cycle whose falling clock edge launched the rising sig_in.
  // The edge is sampled at the next rising clock edge, and a report
  // becomes visible three cycles after launch.
  function automatic void model_rise(int m);
    int k;
    int gap;
    int s;
    k   = m + 1;
    gap = k - m_last;
    if (m_armed && gap <= T) begin
`ifdef CLK_PERIOD_AVG_EN
      win.push_back(gap);
      if (win.size() == 4) begin
        s = 0;
        foreach (win[i]) s += win[i];
        exp_q.push_back('{s / 4, m + 3});
        win.delete();
      end
`else
      s = gap;
      exp_q.push_back('{s, m + 3});
`endif
    end else begin
      m_armed = 1'b1;
      win.delete();
    end
    m_last = k;
    last_m = m;
  endfunction

  always @(negedge clk_in) begin
    if (period_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: period=%0d at cycle %0d, expected no pulse",
                 period, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("period_value", 32'(period), e.value);
        check("period_time", cyc, e.at);
      end
    end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_valid: no pulse at cycle %0d, expected period=%0d",
               exp_q[0].at, exp_q[0].value);
      void'(exp_q.pop_front());
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic rise_now();
    sig_in = 1'b1;
    model_rise(cyc);
  endtask

  task automatic pulse(int p, int h);
    rise_now();
    tick(h);
    sig_in = 1'b0;
    tick(p - h);
  endtask

  task automatic check_idle(string name);
    check({name, "_period"}, 32'(period), 0);
    check({name, "_valid"}, 32'(period_valid), 0);
    check({name, "_stalled"}, 32'(stalled), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tgt;
    int mb;
    int p;
    int h;

    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_idle("reset");
      sig_in = (i == 1);
      if (i == 2) rst = 1'b0;
    end
    tick(1);
    check_idle("post_reset");
    model_reset();

    repeat (10) pulse(16, 8);
    repeat (6) pulse(20, 10);

    tgt = last_m + T + 2;
    while (cyc < tgt) tick(1);
    check("stall_before", 32'(stalled), 0);
    tick(1);
    check("stall_set", 32'(stalled), 1);
    tick(4);
    rise_now();
    tick(2);
    check("stall_hold", 32'(stalled), 1);
    tick(1);
    check("stall_clear", 32'(stalled), 0);
    tick(5);
    sig_in = 1'b0;
    tick(8);
    repeat (3) pulse(16, 8);

    rise_now();
    mb = cyc;
    tick(8);
    sig_in = 1'b0;
    tick(42);
    rise_now();
    while (cyc < mb + T + 3) tick(1);
    check("boundary_no_stall", 32'(stalled), 0);
    tick(5);
    sig_in = 1'b0;
    tick(8);
    repeat (3) pulse(16, 8);

    rise_now();
    tick(8);
    sig_in = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    check_idle("mid_reset");
    rst = 1'b0;
    model_reset();
    tick(2);
    repeat (6) pulse(16, 8);

    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(70, 4));
      h = int'($urandom_range(p - 2, 2));
      pulse(p, h);
    end

    tick(10);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period of a slow, asynchronous square-wave input in cycles of the system clock. It is the receive-side counterpart of the bit-select clock divider: it reports the real divide ratio delivered to downstream logic. Each measured period is reported with a one-cycle valid strobe. A timeout flag is raised when the input stops toggling. It sits beside the divider in the clocking block and feeds status/debug logic.

## Interface
- `CNT_W`, default 32: width of the period counter and the `period` output.
- `TIMEOUT`, default 100_000_000: cycle count without a rising edge that declares the input stalled. Legal range 2 .. 2^CNT_W−1.
- `clk_in`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: reset, synchronous to `clk_in`, active-high.
- `sig_in`, input, 1: measured signal, asynchronous to `clk_in`.
- `period`, output, CNT_W: last reported period in `clk_in` cycles; holds between updates.
- `period_valid`, output, 1: one-cycle pulse, asserted in the cycle `period` takes a new value.
- `stalled`, output, 1: level; no rising edge within `TIMEOUT` cycles.

## Operation
- **Synchronizer:** two flops, `s0` then `s1`, followed by history flop `s2`. Rising edge `rise = s1 & ~s2` (combinational).
- **Counter `cnt` (CNT_W bits):**
  - `rise` → `cnt <= 1`.
  - Otherwise `cnt <= cnt + 1`, saturating at `TIMEOUT`.
  - With rising edges P cycles apart, `cnt == P` in the cycle of the second `rise`.
- **Arming flag `armed`:**
  - Cleared by reset and by stall.
  - A `rise` with `armed=0` sets `armed`. It produces no report and no accumulation.
- **Report:** a `rise` with `armed=1` captures `cnt` as one sample. Without averaging, `period <= cnt` and `period_valid <= 1` in the next cycle.
- **Stall:** `cnt == TIMEOUT`, no `rise` and `stalled=0` → next cycle `stalled <= 1`, `armed <= 0`.
  - The next `rise` clears `stalled` and re-arms.
  - That `rise` is not reported.
- **Simultaneous `rise` and `cnt == TIMEOUT`:** the edge wins. The sample equals `TIMEOUT`, no stall is raised, and `armed` stays set.
- **Reset (including mid-measurement):** the next cycle has all flops at zero.
  - `period=0`, `period_valid=0`, `stalled=0`, `armed=0`, `cnt=0`, synchronizer flops 0, accumulator state 0.
  - The first edge after reset is never reported.
- `period_valid` is never asserted in two consecutive cycles, because edges are at least 2 cycles apart after synchronization.

## Timing
- `sig_in` rising before `clk_in` edge k (meeting setup): `s0=1` after k, `s1=1` after k+1, and `rise` is high in the cycle following edge k+1.
- `period`/`period_valid` update at the edge that ends the `rise` cycle. Total sig_in→valid latency is 3 `clk_in` edges.
- The stall flag asserts one cycle after `cnt` reaches `TIMEOUT`.
- Minimum measurable period is 2. High and low phases of `sig_in` each need at least 2 `clk_in` cycles for reliable capture.
- No backpressure: a consumer must sample `period` on the `period_valid` pulse.

## Configuration
- `CLK_PERIOD_AVG_EN` defined:
  - Samples go into a CNT_W+2-bit accumulator with a 2-bit sample index.
  - On the 4th sample, `period <= (acc + sample) >> 2` (truncated) and `period_valid` pulses. The accumulator and index then clear.
  - Samples 1–3 produce no pulse.
  - Stall or reset clears the accumulator and index.
- `CLK_PERIOD_AVG_EN` not defined: every sample is reported directly; no accumulator logic is present.

## Test plan
- **Reset state:** hold `rst=1` for 3 cycles with `sig_in` toggling → `period=0`, `period_valid=0`, `stalled=0` throughout and one cycle after release.
- **Steady period:** `sig_in` toggles every 8 cycles (period 16). Expect no pulse on the first rising edge. Expect `period_valid` pulses with `period=16` on every subsequent edge (averaging on: first pulse after the 5th edge, value 16).
- **Period change:** 10 edges at period 16, then period 20 → next report 20, spaced 20 cycles apart (averaging: a mixed window reports truncated mean, e.g. 16,16,20,20 → 18).
- **Stall:** `TIMEOUT=50`, period 16, then hold `sig_in=0` → `stalled=1` one cycle after `cnt` reaches 50. On the next edge, `stalled` clears with no report. The following edge reports the true period.
- **Boundary:** `TIMEOUT=50`, single period of exactly 50 → reported `period=50`, `stalled` stays 0.
- **Reset mid-operation:** assert `rst` for 1 cycle 5 cycles after an edge during period-16 operation. Expect no report at the first post-reset edge; the next edge reports 16.
